// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage sequencer for the iterative divider and the
// multi-cycle multiplier; owns the architectural HI/LO registers.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   op_valid, op            EX op present and its code (MULT..MTLO)
//   rs_data, rt_data        operand A/dividend/MT data, operand B/divisor
//   flush                   squash the in-flight or same-cycle op
//   stall                   pipeline stall request
//   rdata                   HI for MFHI, LO for MFLO (combinational)
//   hi, lo                  architectural HI/LO
//   err                     one-cycle pulse on watchdog abort
//   div_start, div_dividend, div_divisor         divider launch
//   div_done, div_quotient, div_remainder        divider result
//   mul_start, mul_a, mul_b, mul_signed          multiplier launch
//   mul_done, mul_product                        multiplier result
module muldiv_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_done,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_signed,
    input  logic        mul_done,
    input  logic [63:0] mul_product
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    typedef logic [WDW-1:0] wd_t;
    localparam wd_t WD_MAX = wd_t'(TIMEOUT);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        div_q, div_d;
    logic        sgn_q, sgn_d;
    wd_t         wd_q, wd_d;

    logic        unit_done;
    wd_t         wd_inc;

    // Only the unit that was launched can complete the operation.
    assign unit_done = div_q ? div_done : mul_done;
    assign wd_inc    = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        div_d     = div_q;
        sgn_d     = sgn_q;
        wd_d      = wd_q;
        err       = 1'b0;
        div_start = 1'b0;
        mul_start = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (op_valid && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            opa_d   = rs_data;
                            opb_d   = rt_data;
                            div_d   = 1'b0;
                            sgn_d   = (op == OP_MULT);
                            state_d = S_LAUNCH;
                        end
                        OP_DIV: begin
                            // Divide by zero is architecturally a no-op.
                            if (rt_data != 32'd0) begin
                                opa_d   = rs_data;
                                opb_d   = rt_data;
                                div_d   = 1'b1;
                                sgn_d   = 1'b0;
                                state_d = S_LAUNCH;
                            end
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            S_LAUNCH: begin
                // The start pulse goes out even if flushed, so the
                // unit must be drained afterwards.
                div_start = div_q;
                mul_start = ~div_q;
                wd_d      = '0;
                state_d   = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_inc;
                if (unit_done) begin
                    // A flush coinciding with done squashes the write;
                    // nothing is left outstanding.
                    state_d = S_IDLE;
                    if (!flush) begin
                        if (div_q) begin
                            hi_d = div_remainder;
                            lo_d = div_quotient;
                        end else begin
                            hi_d = mul_product[63:32];
                            lo_d = mul_product[31:0];
                        end
                    end
                end else if (wd_q == WD_MAX) begin
                    state_d = S_IDLE;
                    err     = ~flush;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                wd_d = wd_inc;
                if (unit_done || wd_q == WD_MAX) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            div_q   <= 1'b0;
            sgn_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            div_q   <= div_d;
            sgn_q   <= sgn_d;
            wd_q    <= wd_d;
        end
    end

    assign stall        = op_valid & (state_q != S_IDLE);
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign div_dividend = opa_q;
    assign div_divisor  = opb_q;
    assign mul_a        = opa_q;
    assign mul_b        = opb_q;
    assign mul_signed   = sgn_q;

    always_comb begin
        rdata = '0;
        case (op)
            OP_MFHI: rdata = hi_q;
            OP_MFLO: rdata = lo_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and randomized checks of muldiv_ctrl against
// a transaction-level model, with emulated divider/multiplier units.
module tb_muldiv_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] rdata, hi, lo;
    logic        err;
    logic        div_start;
    logic [31:0] div_dividend, div_divisor;
    logic        div_done = 1'b0;
    logic [31:0] div_quotient = '0;
    logic [31:0] div_remainder = '0;
    logic        mul_start;
    logic [31:0] mul_a, mul_b;
    logic        mul_signed;
    logic        mul_done = 1'b0;
    logic [63:0] mul_product = '0;

    muldiv_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .flush(flush), .stall(stall), .rdata(rdata),
        .hi(hi), .lo(lo), .err(err),
        .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_signed(mul_signed),
        .mul_done(mul_done), .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic (MIPS semantics).
    function automatic logic [63:0] div_ref(input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    function automatic logic [63:0] mul_ref(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic s);
        longint sa, sb;
        logic [63:0] ua, ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Transaction model: one outstanding op, tracked by its age in
    // cycles since acceptance (age 1 = start pulse cycle).
    bit          m_busy, m_div, m_sgn, m_flushed;
    int          m_age;
    logic [31:0] m_hi, m_lo, m_opa, m_opb;

    // Unit emulator.
    int          emu_cnt;
    bit          emu_div, emu_sgn;
    logic [31:0] emu_a, emu_b;
    int          fixed_lat;
    bit          spur_en;

    logic        last_stall;
    logic [31:0] last_rdata;
    int          err_cnt, start_cnt;

    task automatic model_reset();
        m_busy = 0; m_div = 0; m_sgn = 0; m_flushed = 0; m_age = 0;
        m_hi = '0; m_lo = '0; m_opa = '0; m_opb = '0;
        emu_cnt = 0;
    endtask

    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return $urandom_range(62, 68);
        if (r < 3) return 2;
        return $urandom_range(1, 40);
    endfunction

    // One clock cycle: drive at posedge+1, check at negedge, advance
    // the model with what the DUT saw at the edge.
    task automatic cycle(input logic ov, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        logic        dd, md, edone, eerr;
        logic [63:0] res;
        op_valid = ov; op = o; rs_data = a; rt_data = b; flush = fl;
        div_done = 1'b0;
        mul_done = 1'b0;
        div_quotient  = $urandom;
        div_remainder = $urandom;
        mul_product   = {$urandom, $urandom};
        if (emu_cnt > 0) begin
            emu_cnt--;
            if (emu_cnt == 0) begin
                if (emu_div) begin
                    res = div_ref(emu_a, emu_b);
                    div_done = 1'b1;
                    div_quotient  = res[31:0];
                    div_remainder = res[63:32];
                end else begin
                    mul_done = 1'b1;
                    mul_product = mul_ref(emu_a, emu_b, emu_sgn);
                end
            end
        end
        if (spur_en && $urandom_range(0, 7) == 0) begin
            if (m_busy) begin
                if (m_div) mul_done = 1'b1;
                else       div_done = 1'b1;
            end else if ($urandom_range(0, 1) == 1) begin
                div_done = 1'b1;
            end else begin
                mul_done = 1'b1;
            end
        end
        dd = div_done;
        md = mul_done;
        edone = m_div ? dd : md;

        @(negedge clk);
        eerr = m_busy && !m_flushed && !fl && !edone && m_age == TO + 2;
        chk("stall", stall, ov & m_busy);
        chk("div_start", div_start, m_busy && m_age == 1 && m_div);
        chk("mul_start", mul_start, m_busy && m_age == 1 && !m_div);
        chk("err", err, eerr);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("div_dividend", div_dividend, m_opa);
        chk("div_divisor", div_divisor, m_opb);
        chk("mul_a", mul_a, m_opa);
        chk("mul_b", mul_b, m_opb);
        if (m_busy && !m_div) chk("mul_signed", mul_signed, m_sgn);
        if (ov && o == 3'd4) chk("rdata_hi", rdata, m_hi);
        if (ov && o == 3'd5) chk("rdata_lo", rdata, m_lo);
        last_stall = stall;
        last_rdata = rdata;
        if (err) err_cnt++;
        if (div_start || mul_start) begin
            start_cnt++;
            emu_div = div_start;
            emu_a   = div_start ? div_dividend : mul_a;
            emu_b   = div_start ? div_divisor : mul_b;
            emu_sgn = mul_signed;
            emu_cnt = (fixed_lat > 0) ? fixed_lat : pick_lat();
        end

        @(posedge clk);
        #1;
        if (rst_n) begin
            if (m_busy) begin
                if (m_age >= 2 && edone) begin
                    if (!m_flushed && !fl) begin
                        if (m_div) res = div_ref(m_opa, m_opb);
                        else       res = mul_ref(m_opa, m_opb, m_sgn);
                        m_hi = res[63:32];
                        m_lo = res[31:0];
                    end
                    m_busy = 0;
                end else if (m_age == TO + 2) begin
                    m_busy = 0;
                end else begin
                    if (fl) m_flushed = 1;
                    m_age++;
                end
            end else if (ov && !fl) begin
                if (o <= 3'd1 || (o == 3'd2 && b != 32'd0)) begin
                    m_busy = 1; m_age = 1; m_flushed = 0;
                    m_div = (o == 3'd2);
                    m_sgn = (o == 3'd0);
                    m_opa = a; m_opb = b;
                end else if (o == 3'd6) begin
                    m_hi = a;
                end else if (o == 3'd7) begin
                    m_lo = a;
                end
            end
        end
    endtask

    task automatic idle_cyc();
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_busy && n < 200) begin
            idle_cyc();
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        idle_cyc();
        idle_cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        logic        ov, fl;
        logic [2:0]  o;
        logic [31:0] a, b;
        int          n;

        fixed_lat = 0;
        spur_en = 0;
        err_cnt = 0;
        start_cnt = 0;
        last_stall = 1'b0;
        last_rdata = '0;
        #2;
        do_reset();
        chk("rst_hi", hi, 64'd0);
        chk("rst_lo", lo, 64'd0);

        // DIV 100/7, unit done at T+35.
        fixed_lat = 34;
        start_cnt = 0;
        cycle(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
        wait_idle();
        idle_cyc();
        chk("div100_lo", lo, 64'd14);
        chk("div100_hi", hi, 64'd2);
        chk("div100_starts", start_cnt, 64'd1);

        // DIV -7/2 with early-out latency.
        fixed_lat = 2;
        cycle(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle();
        idle_cyc();
        chk("divneg_lo", lo, 64'hFFFF_FFFD);
        chk("divneg_hi", hi, 64'hFFFF_FFFF);

        // DIV 5/0: nothing launched, HI/LO kept.
        start_cnt = 0;
        cycle(1'b1, 3'd2, 32'd5, 32'd0, 1'b0);
        chk("div0_stall", last_stall, 64'd0);
        idle_cyc();
        idle_cyc();
        chk("div0_starts", start_cnt, 64'd0);
        chk("div0_lo", lo, 64'hFFFF_FFFD);

        // MULTU then back-to-back MFLO.
        fixed_lat = 4;
        cycle(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        n = 0;
        do begin
            cycle(1'b1, 3'd5, 32'd0, 32'd0, 1'b0);
            n++;
        end while (last_stall && n < 100);
        chk("multu_mflo", last_rdata, 64'hFFFF_FFFE);
        chk("multu_hi", hi, 64'd1);

        // MTHI then MFHI.
        cycle(1'b1, 3'd6, 32'h1234, 32'd0, 1'b0);
        chk("mthi_stall", last_stall, 64'd0);
        cycle(1'b1, 3'd4, 32'd0, 32'd0, 1'b0);
        chk("mfhi", last_rdata, 64'h1234);

        // DIV, flush at T+5, new DIV presented from T+6.
        fixed_lat = 34;
        cycle(1'b1, 3'd2, 32'd1000, 32'd10, 1'b0);
        repeat (4) idle_cyc();
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        n = 0;
        do begin
            cycle(1'b1, 3'd2, 32'd77, 32'd5, 1'b0);
            n++;
        end while (last_stall && n < 100);
        chk("flush_stall_len", n > 25, 64'd1);
        wait_idle();
        idle_cyc();
        chk("flush_lo", lo, 64'd15);
        chk("flush_hi", hi, 64'd2);

        // Divider never answers: watchdog abort.
        fixed_lat = 500;
        err_cnt = 0;
        cycle(1'b1, 3'd2, 32'd9, 32'd3, 1'b0);
        wait_idle();
        idle_cyc();
        chk("wd_err_cnt", err_cnt, 64'd1);
        chk("wd_lo", lo, 64'd15);

        // Reset in the middle of a multiply.
        fixed_lat = 30;
        cycle(1'b1, 3'd0, 32'hDEAD_BEEF, 32'h7, 1'b0);
        repeat (10) idle_cyc();
        rst_n = 1'b0;
        model_reset();
        cycle(1'b1, 3'd5, 32'd0, 32'd0, 1'b0);
        chk("rstw_stall", last_stall, 64'd0);
        chk("rstw_hi", hi, 64'd0);
        chk("rstw_a", mul_a, 64'd0);
        idle_cyc();
        rst_n = 1'b1;
        idle_cyc();

        // Randomized traffic.
        fixed_lat = 0;
        spur_en = 1;
        ov = 0; o = 0; a = 0; b = 0;
        for (int i = 0; i < 5000; i++) begin
            if (!(last_stall && ov)) begin
                ov = ($urandom_range(0, 3) != 0);
                o  = 3'($urandom_range(0, 7));
                a  = $urandom;
                case ($urandom_range(0, 7))
                    0:       b = 32'd0;
                    1, 2:    b = 32'($urandom_range(1, 20));
                    3:       b = 32'hFFFF_FFFF;
                    default: b = $urandom;
                endcase
            end
            fl = ($urandom_range(0, 24) == 0);
            cycle(ov, o, a, b, fl);
        end
        spur_en = 0;
        wait_idle();
        idle_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
